// File: rtl/decode_out_pkg.sv
// Shared definitions for the decoder core input/output control blocks.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Holds the readout FSM state encoding, the beat count for each code index
// and the code-index-to-beat-count mapping used by both controllers.
package decode_out_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_READ_ENC  = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_READ  = ST_READ_ENC,
    ST_DRAIN = ST_DRAIN_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_t;

  localparam logic [7:0] BEATS_CODE0  = 8'd8;
  localparam logic [7:0] BEATS_CODE1  = 8'd32;
  localparam logic [7:0] BEATS_CODE2  = 8'd128;
  localparam logic [1:0] CODE_ILLEGAL = 2'd3;

  // Beats per codeword for a code index; the illegal index maps to 0.
  function automatic logic [7:0] code_beats(input logic [1:0] code);
    case (code)
      2'd0:    code_beats = BEATS_CODE0;
      2'd1:    code_beats = BEATS_CODE1;
      2'd2:    code_beats = BEATS_CODE2;
      default: code_beats = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/decode_out_skid.sv
// 2-entry valid/ready buffer between memory read returns and the output port.
// Latency: 0 cycles when empty (incoming word bypasses straight to the output).
// Backpressure: holds up to 2 words; the issue logic uses occupancy to avoid overflow.
//
// Ports: clk/rst (async active-high), clr (synchronous flush), in_valid/in_payload
// (returning word), out_valid/out_ready/out_payload (output beat), occupancy
// (stored entries, excluding a bypassing word).
module decode_out_skid #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload,
  output logic [1:0]   occupancy
);

  logic [W-1:0] entry [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         empty;
  logic         push;
  logic         pop;

  assign empty       = (count == 2'd0);
  assign out_valid   = !empty || in_valid;
  assign out_payload = empty ? in_payload : entry[rd_ptr];
  assign occupancy   = count;

  // A word arriving into an empty buffer while the consumer is ready goes
  // straight through and is never stored.
  assign push = in_valid && !(empty && out_ready);
  assign pop  = !empty && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else if (clr) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        entry[wr_ptr] <= in_payload;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/decode_out_ctrl.sv
// Reads a decoded codeword from the result memory and streams it out with valid/ready.
// Latency: first read 1 cycle after i_start, first beat 2 cycles after; 1 beat/cycle with ready high.
// Backpressure: reads pause while buffered + in-flight words reach 2; no word is ever dropped.
//
// Ports: i_clk/i_rst (async active-high); i_start/i_code/i_mode/i_early_stop
// launch a readout; o_mem_ren/o_mem_raddr/i_mem_rdata/i_err_rdata form the
// 1-cycle-latency memory read port; o_out_* is the output stream; o_busy and
// o_done report progress. Defining DECODE_OUT_PARITY_EN adds o_out_parity,
// the XOR reduction of o_out_data.
module decode_out_ctrl
  import decode_out_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_code,
  input  logic              i_mode,
  input  logic              i_early_stop,
  output logic              o_mem_ren,
  output logic [ADDR_W-1:0] o_mem_raddr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic [DATA_W-1:0] i_err_rdata,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_last,
  output logic              o_out_early_stop,
`ifdef DECODE_OUT_PARITY_EN
  output logic              o_out_parity,
`endif
  output logic              o_busy,
  output logic              o_done
);

`ifdef DECODE_OUT_PARITY_EN
  localparam int PW = DATA_W + 3;
`else
  localparam int PW = DATA_W + 2;
`endif

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        code_q;
  logic              mode_q;
  logic              es_q;
  logic [ADDR_W-1:0] issued;
  logic              rd_inflight;
  logic              rd_last;
  logic [7:0]        beats;
  logic [ADDR_W-1:0] last_addr;
  logic              start_ok;
  logic              issue;
  logic              issue_last;
  logic [1:0]        occ;
  logic [DATA_W-1:0] beat_data;
  logic [PW-1:0]     in_payload;
  logic [PW-1:0]     out_payload;

  assign beats     = code_beats(code_q);
  assign last_addr = ADDR_W'(beats - 8'd1);
  assign start_ok  = (state == ST_IDLE) && i_start && (i_code != CODE_ILLEGAL);

  // Words already buffered plus the word still coming back from memory must
  // never exceed the two buffer entries, whatever the consumer does next.
  assign issue      = (state == ST_READ) && (({1'b0, occ} + {2'b0, rd_inflight}) < 3'd2);
  assign issue_last = issue && (issued == last_addr);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_mem_ren = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_READ;
      end
      ST_READ: begin
        o_busy    = 1'b1;
        o_mem_ren = issue;
        if (issue_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        if (o_out_valid && i_out_ready && o_out_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_busy    = 1'b1;
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      code_q      <= 2'd0;
      mode_q      <= 1'b0;
      es_q        <= 1'b0;
      issued      <= '0;
      rd_inflight <= 1'b0;
      rd_last     <= 1'b0;
    end else begin
      rd_inflight <= issue;
      rd_last     <= issue_last;
      if (start_ok) begin
        code_q <= i_code;
        mode_q <= i_mode;
        es_q   <= i_early_stop;
        issued <= '0;
      end else if (issue && !issue_last) begin
        // The final address is held rather than incremented so it never wraps.
        issued <= issued + 1'b1;
      end
    end
  end

  assign o_mem_raddr = issued;
  assign beat_data   = mode_q ? (i_mem_rdata ^ i_err_rdata) : i_mem_rdata;

  // Payload is forced to zero when nothing is returning so the bypass path
  // cannot leak stale memory data onto an idle output.
`ifdef DECODE_OUT_PARITY_EN
  assign in_payload   = rd_inflight ? {^beat_data, es_q, rd_last, beat_data} : '0;
  assign o_out_parity = out_payload[DATA_W+2];
`else
  assign in_payload   = rd_inflight ? {es_q, rd_last, beat_data} : '0;
`endif

  decode_out_skid #(.W(PW)) u_skid (
    .clk         (i_clk),
    .rst         (i_rst),
    .clr         (start_ok),
    .in_valid    (rd_inflight),
    .in_payload  (in_payload),
    .out_valid   (o_out_valid),
    .out_ready   (i_out_ready),
    .out_payload (out_payload),
    .occupancy   (occ)
  );

  assign o_out_data       = out_payload[DATA_W-1:0];
  assign o_out_last       = out_payload[DATA_W];
  assign o_out_early_stop = out_payload[DATA_W+1];

endmodule

// File: tb/tb_decode_out_ctrl.sv
// Directed-plus-random bench for decode_out_ctrl against a codeword-level model.
// Latency: n/a.  Backpressure: ready is driven always-high, toggling or random.
module tb_decode_out_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] code = 2'd0;
  logic       mode = 1'b0;
  logic       es_in = 1'b0;
  logic       ren;
  logic [6:0] raddr;
  logic [7:0] rdata = 8'd0;
  logic [7:0] erdata = 8'd0;
  logic       valid;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       last;
  logic       es_out;
  logic       par;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  decode_out_ctrl #(.DATA_W(8), .ADDR_W(7)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start),
    .i_code           (code),
    .i_mode           (mode),
    .i_early_stop     (es_in),
    .o_mem_ren        (ren),
    .o_mem_raddr      (raddr),
    .i_mem_rdata      (rdata),
    .i_err_rdata      (erdata),
    .o_out_valid      (valid),
    .i_out_ready      (ready),
    .o_out_data       (data),
    .o_out_last       (last),
    .o_out_early_stop (es_out),
`ifdef DECODE_OUT_PARITY_EN
    .o_out_parity     (par),
`endif
    .o_busy           (busy),
    .o_done           (done)
  );

`ifndef DECODE_OUT_PARITY_EN
  assign par = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result and error-bit memories, one cycle read latency.
  logic [7:0] mem [128];
  logic [7:0] err [128];
  always @(posedge clk) begin
    if (ren) begin
      rdata  <= mem[raddr];
      erdata <= err[raddr];
    end
  end

  // Ready generator: 0 = always high, 1 = toggling, 2 = random.
  int rdy_mode = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       ready = ~ready;
      2:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b1;
    endcase
  end

  // Output monitor, sampled mid-cycle.
  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       e;
    logic       p;
  } beat_t;

  beat_t beat_q[$];
  int    addr_q[$];
  int    cyc = 0;
  int    done_cnt = 0, busy_seen = 0;
  int    first_valid_cyc = -1, first_ren_cyc = -1, last_cyc = -1, done_cyc = -1;
  logic  prev_stall = 1'b0;
  logic [9:0] prev_beat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {valid, es_out, last, data}, {1'b1, prev_beat});
`ifdef DECODE_OUT_PARITY_EN
      if (valid) check("parity", par, ^data);
`endif
      if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid && ready) begin
        beat_q.push_back('{d: data, l: last, e: es_out, p: par});
        if (last) last_cyc = cyc;
      end
      if (ren) begin
        if (first_ren_cyc < 0) first_ren_cyc = cyc;
        addr_q.push_back(int'(raddr));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_seen++;
      prev_stall = valid && !ready;
      prev_beat  = {es_out, last, data};
    end
  end

  function automatic int beats_of(input logic [1:0] c);
    return (c == 2'd0) ? 8 : (c == 2'd1) ? 32 : (c == 2'd2) ? 128 : 0;
  endfunction

  task automatic clear_mon();
    beat_q.delete();
    addr_q.delete();
    done_cnt = 0;
    busy_seen = 0;
    first_valid_cyc = -1;
    first_ren_cyc = -1;
    last_cyc = -1;
    done_cyc = -1;
  endtask

  // kind 0: mem = address; 1: FF/0F; 2: random; 3: all 07.
  task automatic fill(input int kind);
    for (int i = 0; i < 128; i++) begin
      case (kind)
        0:       begin mem[i] = 8'(i);           err[i] = 8'($urandom); end
        1:       begin mem[i] = 8'hFF;           err[i] = 8'h0F;        end
        3:       begin mem[i] = 8'h07;           err[i] = 8'($urandom); end
        default: begin mem[i] = 8'($urandom);    err[i] = 8'($urandom); end
      endcase
    end
  endtask

  int start_cyc;

  task automatic pulse_start(input logic [1:0] c, input logic m, input logic e);
    @(posedge clk);
    #1;
    start = 1'b1; code = c; mode = m; es_in = e;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0; es_in = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  // Expected codeword computed from the memories and the launch parameters.
  task automatic check_stream(input string tag, input logic [1:0] c, input logic m, input logic e);
    int nb = beats_of(c);
    int bad_addr = 0;
    logic [7:0] exp_d;
    check({tag, "_beat_count"}, beat_q.size(), nb);
    check({tag, "_read_count"}, addr_q.size(), nb);
    for (int k = 0; k < addr_q.size(); k++)
      if (addr_q[k] != k) bad_addr++;
    check({tag, "_addr_seq_errors"}, bad_addr, 0);
    for (int k = 0; k < beat_q.size() && k < nb; k++) begin
      exp_d = m ? (mem[k] ^ err[k]) : mem[k];
      check($sformatf("%s_data[%0d]", tag, k), beat_q[k].d, exp_d);
      check($sformatf("%s_last[%0d]", tag, k), beat_q[k].l, (k == nb - 1));
      check($sformatf("%s_es[%0d]", tag, k), beat_q[k].e, e);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_ren"}, ren, 0);
    check({tag, "_raddr"}, raddr, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_last"}, last, 0);
    check({tag, "_es"}, es_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
`ifdef DECODE_OUT_PARITY_EN
    check({tag, "_parity"}, par, 0);
`endif
  endtask

  initial begin
    int n;
    logic m4;

    // Reset state.
    #3;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Code 0, raw, ready high, word = address: exact timing.
    fill(0);
    clear_mon();
    rdy_mode = 0;
    pulse_start(2'd0, 1'b0, 1'b0);
    wait_done("c0");
    check("c0_first_ren_cyc", first_ren_cyc - start_cyc, 1);
    check("c0_first_valid_cyc", first_valid_cyc - start_cyc, 2);
    check("c0_last_cyc", last_cyc - start_cyc, 1 + 8);
    check("c0_done_cyc", done_cyc - start_cyc, 2 + 8);
    check("c0_busy_cycles", busy_seen, 8 + 2);
    check_stream("c0", 2'd0, 1'b0, 1'b0);

    // Code 1, corrected: FF ^ 0F.
    fill(1);
    clear_mon();
    pulse_start(2'd1, 1'b1, 1'b0);
    wait_done("c1");
    check("c1_done_cyc", done_cyc - start_cyc, 2 + 32);
    check_stream("c1", 2'd1, 1'b1, 1'b0);

    // Code 2, random data, ready toggling every cycle.
    fill(2);
    clear_mon();
    rdy_mode = 1;
    pulse_start(2'd2, 1'b0, 1'b0);
    wait_done("c2");
    check("c2_done_after_last", done_cyc - last_cyc, 1);
    check_stream("c2", 2'd2, 1'b0, 1'b0);

    // Early stop latched; a second start mid-readout must be ignored.
    fill(2);
    clear_mon();
    rdy_mode = 2;
    m4 = 1'($urandom_range(0, 1));
    pulse_start(2'd1, m4, 1'b1);
    n = 0;
    while (beat_q.size() < 10 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("es_reached_beat10", beat_q.size() >= 10, 1);
    pulse_start(2'd0, ~m4, 1'b0);
    wait_done("es");
    check_stream("es", 2'd1, m4, 1'b1);

    // Async reset at beat 5, then a clean readout.
    fill(2);
    clear_mon();
    rdy_mode = 0;
    pulse_start(2'd1, 1'b0, 1'b0);
    n = 0;
    while (beat_q.size() < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_beat5", beat_q.size(), 5);
    #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
    pulse_start(2'd1, 1'b0, 1'b0);
    wait_done("post_rst");
    check_stream("post_rst", 2'd1, 1'b0, 1'b0);

    // Illegal code index is ignored.
    clear_mon();
    pulse_start(2'd3, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("illegal_busy_cycles", busy_seen, 0);
    check("illegal_reads", addr_q.size(), 0);
    check("illegal_beats", beat_q.size(), 0);

`ifdef DECODE_OUT_PARITY_EN
    // Data 07 has odd weight, so parity is 1 on every beat.
    fill(3);
    clear_mon();
    pulse_start(2'd0, 1'b0, 1'b0);
    wait_done("par");
    check_stream("par", 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < beat_q.size(); k++)
      check($sformatf("par_bit[%0d]", k), beat_q[k].p, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_out_ctrl.md
# decode_out_ctrl

Output-side controller of the decoder core: the read counterpart to the input control block that fills the LLR and syndrome memories. After a decode completes, it reads the decoded codeword out of the result memory one word per cycle. It optionally applies the saved error-bit corrections and streams the words to the core output port with a valid/ready handshake and a last-beat marker. It sits between the result/error-bit memories and the core top-level output pins.

## Interface
Parameters:
- DATA_W, 8, bits per output beat and per memory word
- ADDR_W, 7, memory address width; must cover 128 beats

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  one-cycle pulse: decode finished, begin readout
- i_code  in  2  code index latched at i_start: 0→8 beats, 1→32 beats, 2→128 beats; 3 is illegal
- i_mode  in  1  latched at i_start: 0 = raw hard decision, 1 = apply error-bit correction
- i_early_stop  in  1  early-stop flag, latched at i_start
- o_mem_ren  out  1  read enable to result and error-bit memories
- o_mem_raddr  out  ADDR_W  read address
- i_mem_rdata  in  DATA_W  result word, valid exactly 1 cycle after o_mem_ren
- i_err_rdata  in  DATA_W  error-bit word, same timing as i_mem_rdata
- o_out_valid  out  1  beat valid
- i_out_ready  in  1  downstream accepts the beat
- o_out_data  out  DATA_W  beat data
- o_out_last  out  1  final beat of the codeword
- o_out_early_stop  out  1  latched early-stop flag, qualified by o_out_valid
- o_busy  out  1  readout in progress
- o_done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On i_start, latch code, mode and early_stop.
  - Clear the read address, issued count and buffer.
  - Go to READ.
  - i_code==3 at i_start is ignored; stay in IDLE.
- READ:
  - Issue o_mem_ren with address = issued count when buffer occupancy + in-flight reads < 2.
  - Increment the address after each issue.
  - When the issued count reaches BEATS-1 and that read issues, go to DRAIN.
- DRAIN: no further reads. Go to DONE when the last beat is accepted (o_out_valid & i_out_ready & o_out_last).
- DONE: assert o_done for one cycle, then return to IDLE.
- Returned data:
  - mode 0: i_mem_rdata is pushed into the 2-entry skid buffer unchanged.
  - mode 1: i_mem_rdata ^ i_err_rdata is pushed.
- o_out_last is asserted on the beat whose address was BEATS-1.
- Address is ADDR_W wide and never wraps. Counters compare against BEATS-1 per code.
- i_start while o_busy=1 is ignored; latched fields are unchanged.
- A beat held with o_out_valid=1 and i_out_ready=0 keeps its data, last and early_stop stable.
- Async i_rst mid-readout: immediately IDLE, buffer emptied, all outputs 0. Any in-flight read data is discarded.

## Timing
- Reset value of every output is 0; raddr resets to 0.
- o_busy=1 from the cycle after i_start through the DONE cycle inclusive.
- With i_start at cycle t:
  - first o_mem_ren at t+1, address 0
  - first o_out_valid at t+2
- i_out_ready held high gives 1 beat/cycle with no bubbles:
  - last beat at t+1+BEATS
  - o_done at t+2+BEATS
- Backpressure: a read issued while ready drops is absorbed by the second buffer entry, so no data is lost. Reads resume the cycle after occupancy falls.
- When a beat is accepted and a new memory word returns in the same cycle, both happen and occupancy is unchanged.

## Configuration
- DECODE_OUT_PARITY_EN defined:
  - Adds output port o_out_parity (1 bit), the even parity (XOR reduction) of o_out_data.
  - Parity is stored in the buffer alongside the data and qualified by o_out_valid.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - state encoding localparams
  - beat counts per code index (8, 32, 128)
  - the code-index-to-BEATS function, shared with the input controller
- One sub-module: decode_out_skid, a 2-entry valid/ready buffer. It carries data, last, early_stop and optional parity, and reports its occupancy to the issue logic.

## Test plan
- code 0, mode 0, ready=1, mem word = address: i_start at t → beats 0..7 at t+2..t+9, last on beat 7, o_done at t+10.
- code 1, mode 1, mem=8'hFF, err=8'h0F → 32 beats of 8'hF0, o_mem_raddr 0..31 with no skips.
- code 2, ready toggling 1/0 each cycle → all 128 beats in order with none duplicated or lost, data stable while stalled, o_done one cycle after the final handshake.
- i_early_stop=1 at i_start, then i_start and i_early_stop=0 re-pulsed mid-readout → o_out_early_stop=1 on every beat, second start ignored.
- i_rst asserted at beat 5 of code 1 → next edge all outputs 0; a new i_start then gives a clean 32-beat readout from address 0.
- i_code=3 with i_start → o_busy stays 0, no o_mem_ren; with DECODE_OUT_PARITY_EN, data 8'h07 → o_out_parity=1.
